// File: rtl/spi_slave_if.sv
// Bus bundle for spi_slave: SPI pins plus the local tx/rx byte handshakes.
// Both tx and rx transfer a word on a clk edge where valid && ready are both high; valid never waits on ready.
interface spi_slave_if #(
  parameter int DATA_LENGTH = 8
);
  logic                   spi_sck;
  logic                   spi_cs_n;
  logic                   spi_mosi;
  logic                   spi_miso;
  logic                   spi_miso_oe;
  logic [DATA_LENGTH-1:0] tx_data;
  logic                   tx_valid;
  logic                   tx_ready;
  logic [DATA_LENGTH-1:0] rx_data;
  logic                   rx_valid;
  logic                   rx_ready;
  logic                   rx_overrun;
  logic                   busy;

  modport slave (
    input  spi_sck, spi_cs_n, spi_mosi, tx_data, tx_valid, rx_ready,
    output spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid, rx_overrun, busy
  );

  modport master (
    output spi_sck, spi_cs_n, spi_mosi, tx_data, tx_valid, rx_ready,
    input  spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid, rx_overrun, busy
  );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 MSB-first slave, oversampled in the clk domain, with one-entry tx buffer and rx holding register.
// Optional feature macro: SPI_SLAVE_OVERRUN_EN (drop frames arriving while rx_data is unread, flag rx_overrun).
module spi_slave #(
  parameter int                     DATA_LENGTH = 8,
  parameter logic [DATA_LENGTH-1:0] TX_IDLE     = '0,
  parameter int                     SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  spi_slave_if.slave  bus
);

  localparam int                CNT_W    = (DATA_LENGTH > 2) ? $clog2(DATA_LENGTH) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_LENGTH - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic                   sck_q;
  logic                   sck_s, cs_s, mosi_s;
  logic                   sck_rise, sck_fall;

  logic [DATA_LENGTH-1:0] tx_shift, tx_buf, preload;
  logic                   tx_full, tx_accept;
  logic [DATA_LENGTH-1:0] rx_shift, rx_data_q, rx_word;
  logic                   rx_valid_q, rx_hs;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   shift_en, frame_done, commit, frame_keep;

  // cs sync resets high so a fresh reset never looks like a chip-select fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_q     <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.spi_sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
      sck_q     <= sck_s;
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_q;
  assign sck_fall = ~sck_s & sck_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!cs_s) state_next = ACTIVE;
      ACTIVE:  if (cs_s)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign shift_en   = (state == ACTIVE) && !cs_s;
  assign frame_done = shift_en && sck_rise && (bit_cnt == CNT_LAST);
  // A word is committed at chip-select fall and at the trailing fall of every completed frame.
  assign commit     = ((state == IDLE) && !cs_s) || (shift_en && sck_fall && (bit_cnt == '0));
  assign preload    = tx_full ? tx_buf : TX_IDLE;
  assign tx_accept  = bus.tx_valid && !tx_full;
  assign rx_hs      = rx_valid_q && bus.rx_ready;
  assign rx_word    = {rx_shift[DATA_LENGTH-2:0], mosi_s};

`ifdef SPI_SLAVE_OVERRUN_EN
  logic rx_overrun_q;
  logic drop;

  assign drop       = frame_done && rx_valid_q && !rx_hs;
  assign frame_keep = frame_done && !drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rx_overrun_q <= 1'b0;
    else if (drop)   rx_overrun_q <= 1'b1;
    else if (rx_hs)  rx_overrun_q <= 1'b0;
  end

  assign bus.rx_overrun = rx_overrun_q;
`else
  assign frame_keep     = frame_done;
  assign bus.rx_overrun = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_full    <= 1'b0;
      tx_buf     <= '0;
      tx_shift   <= TX_IDLE;
      rx_shift   <= '0;
      bit_cnt    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      // A commit in the same cycle as a write only ever sees an empty buffer, so the write wins.
      if (commit)    tx_full <= 1'b0;
      if (tx_accept) begin
        tx_full <= 1'b1;
        tx_buf  <= bus.tx_data;
      end

      if ((state == IDLE) || commit)  tx_shift <= preload;
      else if (shift_en && sck_fall)  tx_shift <= tx_shift << 1;

      if (shift_en && sck_rise) begin
        rx_shift <= rx_word;
        bit_cnt  <= (bit_cnt == CNT_LAST) ? '0 : bit_cnt + CNT_W'(1);
      end else if (cs_s) begin
        bit_cnt  <= '0;
      end

      if (frame_keep) begin
        rx_data_q  <= rx_word;
        rx_valid_q <= 1'b1;
      end else if (rx_hs) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign bus.spi_miso    = tx_shift[DATA_LENGTH-1];
  assign bus.spi_miso_oe = ~cs_s;
  assign bus.tx_ready    = ~tx_full;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  // busy is the full FSM state (two states), so it doubles as the state debug output.
  assign bus.busy        = (state == ACTIVE);

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: SPI master tasks, byte-level reference model with an expected MISO queue.
module tb_spi_slave;

  localparam int          DW      = 8;
  localparam logic [7:0]  TX_IDLE = 8'h00;
  localparam int          SYNC    = 2;
  localparam int          HALF    = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  spi_slave_if #(.DATA_LENGTH(DW)) bus ();

  spi_slave #(
    .DATA_LENGTH (DW),
    .TX_IDLE     (TX_IDLE),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: byte-level view of buffer, rx register and overrun flag.
  logic [DW-1:0] exp_q[$];
  logic          m_pending;
  logic [DW-1:0] m_buf;
  logic [DW-1:0] m_rx_data;
  logic          m_rx_valid;
  logic          m_overrun;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic void m_reset();
    m_pending  = 1'b0;
    m_buf      = '0;
    m_rx_data  = '0;
    m_rx_valid = 1'b0;
    m_overrun  = 1'b0;
    exp_q.delete();
  endfunction

  function automatic void m_commit();
    exp_q.push_back(m_pending ? m_buf : TX_IDLE);
    m_pending = 1'b0;
  endfunction

  function automatic void m_frame_done(input logic [DW-1:0] b);
`ifdef SPI_SLAVE_OVERRUN_EN
    if (m_rx_valid) begin
      m_overrun = 1'b1;
    end else begin
      m_rx_data  = b;
      m_rx_valid = 1'b1;
    end
`else
    m_rx_data  = b;
    m_rx_valid = 1'b1;
`endif
  endfunction

  task automatic tx_write(input logic [DW-1:0] d);
    check("tx_ready_pre_write", bus.tx_ready, !m_pending);
    bus.tx_valid = 1'b1;
    bus.tx_data  = d;
    wait_clk(1);
    bus.tx_valid = 1'b0;
    if (!m_pending) begin
      m_pending = 1'b1;
      m_buf     = d;
    end
  endtask

  task automatic rx_read();
    bus.rx_ready = 1'b1;
    wait_clk(1);
    bus.rx_ready = 1'b0;
    if (m_rx_valid) begin
      m_rx_valid = 1'b0;
      m_overrun  = 1'b0;
    end
  endtask

  task automatic cs_low();
    bus.spi_cs_n = 1'b0;
    m_commit();
  endtask

  task automatic cs_high();
    wait_clk(HALF);
    bus.spi_cs_n = 1'b1;
    exp_q.delete();
    wait_clk(HALF + 4);
  endtask

  task automatic xfer(input logic [DW-1:0] mosi, input int nbits, output logic [DW-1:0] got);
    logic [DW-1:0] exp;
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      bus.spi_mosi = mosi[DW-1-i];
      wait_clk(HALF);
      got[DW-1-i] = bus.spi_miso;
      if (i == 0) begin
        check("busy_in_frame", bus.busy, 1'b1);
        check("miso_oe_in_frame", bus.spi_miso_oe, 1'b1);
      end
      bus.spi_sck = 1'b1;
      wait_clk(HALF);
      bus.spi_sck = 1'b0;
    end
    if (nbits == DW) begin
      if (exp_q.size() == 0) begin
        check("exp_q_empty", 32'd1, 32'd0);
      end else begin
        exp = exp_q.pop_front();
        check("miso_byte", got, exp);
      end
      m_frame_done(mosi);
      m_commit();
    end
  endtask

  task automatic frame(input logic [DW-1:0] mosi, output logic [DW-1:0] got);
    cs_low();
    xfer(mosi, DW, got);
    cs_high();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_rx_data"},    bus.rx_data,     m_rx_data);
    check({tag, "_rx_valid"},   bus.rx_valid,    m_rx_valid);
    check({tag, "_rx_overrun"}, bus.rx_overrun,  m_overrun);
    check({tag, "_tx_ready"},   bus.tx_ready,    !m_pending);
    check({tag, "_busy"},       bus.busy,        1'b0);
    check({tag, "_miso_oe"},    bus.spi_miso_oe, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_miso"},       bus.spi_miso,    1'b0);
    check({tag, "_miso_oe"},    bus.spi_miso_oe, 1'b0);
    check({tag, "_tx_ready"},   bus.tx_ready,    1'b1);
    check({tag, "_rx_data"},    bus.rx_data,     32'h0);
    check({tag, "_rx_valid"},   bus.rx_valid,    1'b0);
    check({tag, "_rx_overrun"}, bus.rx_overrun,  1'b0);
    check({tag, "_busy"},       bus.busy,        1'b0);
  endtask

  initial begin
    logic [DW-1:0] got;
    logic [DW-1:0] mo;
    int            nf;

    bus.spi_sck  = 1'b0;
    bus.spi_cs_n = 1'b1;
    bus.spi_mosi = 1'b0;
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    bus.rx_ready = 1'b0;
    m_reset();

    // Power-on reset
    wait_clk(3);
    check_reset_values("por");
    rst_n = 1'b1;
    wait_clk(5);

    // Preloaded tx byte, master sends 'h3C
    tx_write(8'hA5);
    check("t2_tx_ready_full", bus.tx_ready, 1'b0);
    cs_low();
    wait_clk(4);
    check("t2_tx_ready_after_cs", bus.tx_ready, 1'b1);
    xfer(8'h3C, DW, got);
    check("t2_miso_a5", got, 8'hA5);
    cs_high();
    check("t2_rx_data", bus.rx_data, 8'h3C);
    check_idle("t2");
    rx_read();

    // No buffered byte: master receives TX_IDLE
    frame(8'hFF, got);
    check("t3_miso_idle", got, TX_IDLE);
    check("t3_rx_data", bus.rx_data, 8'hFF);
    check_idle("t3");
    rx_read();

    // Back-to-back frames with a write landing during frame 1
    cs_low();
    fork
      xfer(8'h12, DW, got);
      begin
        wait_clk(20);
        tx_write(8'h56);
      end
    join
    check("t4_rx_data_1", bus.rx_data, 8'h12);
    rx_read();
    xfer(8'h34, DW, got);
    check("t4_miso_56", got, 8'h56);
    cs_high();
    check("t4_rx_data_2", bus.rx_data, 8'h34);
    check_idle("t4");
    rx_read();

    // Partial frame is discarded; next full frame decodes
    cs_low();
    xfer(8'hE7, 5, got);
    cs_high();
    check("t5_rx_valid", bus.rx_valid, 1'b0);
    frame(8'h81, got);
    check("t5_rx_data", bus.rx_data, 8'h81);
    check_idle("t5");
    rx_read();

    // Two unread frames
    frame(8'hAA, got);
    frame(8'h55, got);
`ifdef SPI_SLAVE_OVERRUN_EN
    check("t6_rx_data", bus.rx_data, 8'hAA);
    check("t6_overrun", bus.rx_overrun, 1'b1);
`else
    check("t6_rx_data", bus.rx_data, 8'h55);
    check("t6_overrun", bus.rx_overrun, 1'b0);
`endif
    check_idle("t6");
    rx_read();
    check_idle("t6_read");

    // Reset mid-frame with a full tx buffer
    cs_low();
    xfer(8'hC3, 3, got);
    tx_write(8'h77);
    rst_n = 1'b0;
    wait_clk(1);
    check_reset_values("t1_mid");
    bus.spi_cs_n = 1'b1;
    bus.spi_sck  = 1'b0;
    m_reset();
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(4);
    check("t1_tx_ready", bus.tx_ready, 1'b1);
    frame(8'h9E, got);
    check("t1_rx_data", bus.rx_data, 8'h9E);
    check_idle("t1");
    rx_read();

    // Randomized traffic against the model
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 1) == 1) tx_write(DW'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) == 0) tx_write(DW'($urandom_range(0, 255)));
      nf = $urandom_range(1, 2);
      cs_low();
      for (int f = 0; f < nf; f++) begin
        mo = DW'($urandom_range(0, 255));
        xfer(mo, DW, got);
      end
      cs_high();
      check_idle("rnd");
      if ($urandom_range(0, 1) == 1) begin
        rx_read();
        check_idle("rnd_read");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
